// File: rtl/noise_gate.sv
// Sample-rate noise gate: peak envelope follower, hysteretic open/close thresholds,
// hold timer and a linear gain ramp applied to the sample stream one clock later.
module noise_gate #(
    parameter int unsigned Width       = 24,
    parameter int unsigned HoldSamples = 480,
    parameter int unsigned RampStep    = 8,
    parameter int unsigned DecayShift  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [Width-1:0] in_signal,
    input  logic        [Width-1:0] open_thresh,
    input  logic        [Width-1:0] close_thresh,
    output logic                    out_valid,
    output logic signed [Width-1:0] out_signal,
    output logic                    gate_open
);

    typedef enum logic [2:0] {StClosed, StAttack, StOpen, StHold, StRelease} state_e;

    localparam logic [8:0]              GainFull = 9'd256;
    localparam logic [9:0]              Step     = 10'(RampStep);
    localparam logic [15:0]             HoldLoad = 16'(HoldSamples - 1);
    localparam logic signed [Width-1:0] MinVal   = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Width-1:0]        MaxMag   = {1'b0, {(Width-1){1'b1}}};

    state_e                    state_q, state_d;
    logic [8:0]                gain_q, gain_d;
    logic [15:0]               hold_q, hold_d;
    logic [Width-1:0]          env_q, env_d;
    logic signed [Width-1:0]   out_q, out_d;
    logic                      out_valid_q;

    logic [Width-1:0]          mag, env_decay, env_next;
    logic [9:0]                gain_up;
    logic [8:0]                gain_inc, gain_dec;
    logic signed [Width+9:0]   prod;
    logic                      above_open;

    always_comb begin
        // Negating the most negative value would overflow, so clamp it.
        if (in_signal == MinVal) begin
            mag = MaxMag;
        end else if (in_signal[Width-1]) begin
            mag = $unsigned(-in_signal);
        end else begin
            mag = $unsigned(in_signal);
        end
        env_decay  = env_q - (env_q >> DecayShift);
        env_next   = (mag > env_decay) ? mag : env_decay;
        above_open = env_next > open_thresh;
        gain_up    = {1'b0, gain_q} + Step;
        gain_inc   = (gain_up > 10'd256) ? GainFull : gain_up[8:0];
        gain_dec   = ({1'b0, gain_q} > Step) ? 9'(gain_q - Step[8:0]) : 9'd0;
        prod       = in_signal * $signed({1'b0, gain_q});
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        env_d   = env_q;
        out_d   = out_q;
        if (in_valid) begin
            env_d = env_next;
            out_d = Width'(prod >>> 8);
            unique case (state_q)
                StClosed: begin
                    // Entering attack applies the first ramp step on the triggering sample.
                    if (above_open) begin
                        gain_d  = gain_inc;
                        state_d = (gain_inc == GainFull) ? StOpen : StAttack;
                    end
                end
                StAttack: begin
                    gain_d = gain_inc;
                    if (gain_inc == GainFull) state_d = StOpen;
                end
                StOpen: begin
                    if (env_next < close_thresh) begin
                        state_d = StHold;
                        hold_d  = HoldLoad;
                    end
                end
                StHold: begin
                    if (above_open) begin
                        state_d = StOpen;
                    end else if (hold_q == 16'd0) begin
                        state_d = StRelease;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                StRelease: begin
                    if (above_open) begin
                        gain_d  = gain_inc;
                        state_d = (gain_inc == GainFull) ? StOpen : StAttack;
                    end else begin
                        gain_d = gain_dec;
                        if (gain_dec == 9'd0) state_d = StClosed;
                    end
                end
                default: state_d = StClosed;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StClosed;
            gain_q      <= '0;
            hold_q      <= '0;
            env_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            hold_q      <= hold_d;
            env_q       <= env_d;
            out_q       <= out_d;
            out_valid_q <= in_valid;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_signal = out_q;
    assign gate_open  = (state_q != StClosed);

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: directed test-plan sequences followed by randomized
// traffic, all compared against a sample-level behavioural model.
module tb_noise_gate;

    localparam int W  = 24;
    localparam int HS = 4;
    localparam int RS = 64;
    localparam int DS = 1;

    localparam int MClosed  = 0;
    localparam int MAttack  = 1;
    localparam int MOpen    = 2;
    localparam int MHold    = 3;
    localparam int MRelease = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_signal = '0;
    logic        [W-1:0] open_t = 24'd500;
    logic        [W-1:0] close_t = 24'd200;
    logic                out_valid;
    logic signed [W-1:0] out_signal;
    logic                gate_open;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_env  = 0;
    int m_gain = 0;
    int m_hold = 0;
    int m_mode = MClosed;
    int last_out = 0;

    noise_gate #(
        .Width      (W),
        .HoldSamples(HS),
        .RampStep   (RS),
        .DecayShift (DS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_signal   (in_signal),
        .open_thresh (open_t),
        .close_thresh(close_t),
        .out_valid   (out_valid),
        .out_signal  (out_signal),
        .gate_open   (gate_open)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_env = 0; m_gain = 0; m_hold = 0; m_mode = MClosed; last_out = 0;
    endtask

    // One valid sample through the gate, straight from the behavioural rules.
    task automatic model(input int s, output int exp_out);
        int mag, dec, envn, up, dn;
        bit hi, lo;
        longint p;
        mag  = (s == -(1 << 23)) ? (1 << 23) - 1 : ((s < 0) ? -s : s);
        dec  = m_env - (m_env >> DS);
        envn = (mag > dec) ? mag : dec;
        p    = longint'(s) * longint'(m_gain);
        exp_out = int'(p >>> 8);
        up   = (m_gain + RS > 256) ? 256 : m_gain + RS;
        dn   = (m_gain - RS < 0) ? 0 : m_gain - RS;
        hi   = envn > int'(open_t);
        lo   = envn < int'(close_t);
        m_env = envn;
        case (m_mode)
            MClosed, MRelease: begin
                if (hi) begin
                    m_gain = up;
                    m_mode = (up == 256) ? MOpen : MAttack;
                end else if (m_mode == MRelease) begin
                    m_gain = dn;
                    if (dn == 0) m_mode = MClosed;
                end
            end
            MAttack: begin
                m_gain = up;
                if (up == 256) m_mode = MOpen;
            end
            MOpen: if (lo) begin m_mode = MHold; m_hold = HS - 1; end
            default: begin
                if (hi) m_mode = MOpen;
                else if (m_hold == 0) m_mode = MRelease;
                else m_hold = m_hold - 1;
            end
        endcase
    endtask

    task automatic step(input logic v, input int s);
        int e;
        in_valid  = v;
        in_signal = s[W-1:0];
        if (v) begin
            model(s, e);
            last_out = e;
        end
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(v));
        check(v ? "out_signal" : "idle_out_signal", int'(out_signal), last_out);
        check(v ? "gate_open" : "idle_gate_open", int'(gate_open), int'(m_mode != MClosed));
        in_valid = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_out_signal", int'(out_signal), 0);
        check("rst_gate_open", int'(gate_open), 0);
        check("rst_out_valid", int'(out_valid), 0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    int ramp_exp[6] = '{0, 250, 500, 750, 1000, 1000};

    initial begin
        int s, r;
        #12 rst = 1'b0;
        #1;
        check("reset_out_signal", int'(out_signal), 0);
        check("reset_gate_open", int'(gate_open), 0);
        check("reset_out_valid", int'(out_valid), 0);

        // Reset mid-attack
        for (int i = 0; i < 3; i++) step(1'b1, 1000);
        check("attack_before_rst", int'(gate_open), 1);
        async_reset();
        step(1'b1, 100);
        check("post_rst_out", int'(out_signal), 0);

        // Open and ramp
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1000);
            check("ramp_out", int'(out_signal), ramp_exp[i]);
        end
        // Hold then release
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 0);
            if (i == 9) check("release_still_open", int'(gate_open), 1);
        end
        check("closed_after_release", int'(gate_open), 0);

        // Retrigger in release at gain 128
        for (int i = 0; i < 5; i++) step(1'b1, 1000);
        for (int i = 0; i < 9; i++) step(1'b1, 0);
        step(1'b1, -2000);
        check("retrigger_out", int'(out_signal), -1000);
        step(1'b1, 1000);
        check("retrigger_gain192", int'(out_signal), 750);

        // Hysteresis and full-scale negative passthrough
        step(1'b1, 1000);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 300);
            check("hyst_open", int'(gate_open), 1);
        end
        step(1'b1, -(1 << 23));
        check("min_passthrough", int'(out_signal), -(1 << 23));
        step(1'b1, 300);
        check("after_min_out", int'(out_signal), 300);

        // Idle gaps
        for (int i = 0; i < 8; i++) begin
            step(1'b1, int'($urandom_range(0, 1200)) - 600);
            for (int g = 0; g < 3; g++) step(1'b0, int'($urandom));
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 250) begin
                open_t  = 24'($urandom_range(0, 3000));
                close_t = 24'($urandom_range(0, int'(open_t)));
                if (i == 1750) begin open_t = '0; close_t = '0; end
            end
            if ($urandom_range(0, 399) == 0) async_reset();
            r = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: s = int'($urandom_range(0, 200)) - 100;
                4, 5, 6:    s = int'($urandom_range(0, 8000)) - 4000;
                7, 8:       s = r >>> 8;
                default:    s = ($urandom_range(0, 1) == 0) ? -(1 << 23) : 0;
            endcase
            step($urandom_range(0, 3) != 0, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
